// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field widths and the result/flag bundle
// that is stored in the result collector FIFO.
package fp32_pkg;
  localparam int FP32_W = 32;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;

  typedef struct packed {
    logic [FP32_W-1:0] result;
    logic              overflow;
    logic              error;
  } fp32_res_t;
endpackage

// File: rtl/fp32_res_fifo.sv
// Power-of-two FIFO holding fp32_res_t entries.
// The caller guarantees push only when not full and pop only when not empty.
module fp32_res_fifo
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  fp32_res_t              wdata,
  output fp32_res_t              rdata,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  fp32_res_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fp32_result_collector.sv
// Captures FP32 adder results with their flags into a FIFO behind a
// valid/ready port and keeps sticky exception flags.
// Define FP_FLAG_COUNT_EN to add saturating overflow/error event counters.
module fp32_result_collector
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_result,
  input  logic                   in_overflow,
  input  logic                   in_error,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic                   out_overflow,
  output logic                   out_error,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   clear_flags,
  output logic                   sticky_ovf,
  output logic                   sticky_err
`ifdef FP_FLAG_COUNT_EN
  ,
  output logic [CW-1:0]          ovf_cnt,
  output logic [CW-1:0]          err_cnt
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  fp32_res_t wdata;
  fp32_res_t head;
  logic      push;
  logic      pop;

  // Handshakes depend only on the registered level.
  assign in_ready  = (level != FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wdata = '{result: in_result, overflow: in_overflow, error: in_error};

  fp32_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .level (level)
  );

  assign out_result   = out_valid ? head.result   : '0;
  assign out_overflow = out_valid ? head.overflow : 1'b0;
  assign out_error    = out_valid ? head.error    : 1'b0;

  // A flagged push in the same cycle as clear_flags leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_ovf <= 1'b0;
      sticky_err <= 1'b0;
    end else begin
      sticky_ovf <= (sticky_ovf && !clear_flags) || (push && in_overflow);
      sticky_err <= (sticky_err && !clear_flags) || (push && in_error);
    end
  end

`ifdef FP_FLAG_COUNT_EN
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                              input logic hit,
                                              input logic clr);
    logic [CW-1:0] base;
    base = clr ? '0 : cnt;
    if (hit && (base != '1)) return base + CW'(1);
    return base;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt <= '0;
      err_cnt <= '0;
    end else begin
      ovf_cnt <= cnt_next(ovf_cnt, push && in_overflow, clear_flags);
      err_cnt <= cnt_next(err_cnt, push && in_error, clear_flags);
    end
  end
`endif
endmodule

// File: tb/tb_fp32_result_collector.sv
// Scoreboard bench for fp32_result_collector: directed pushes queue their
// expected entries, a monitor compares every popped head in order.
module tb_fp32_result_collector;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_error;
  logic [2:0]  level;
  logic        clear_flags;
  logic        sticky_ovf;
  logic        sticky_err;
`ifdef FP_FLAG_COUNT_EN
  logic [CW-1:0] ovf_cnt;
  logic [CW-1:0] err_cnt;
`endif

  fp32_result_collector #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .in_error     (in_error),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_error    (out_error),
    .level        (level),
    .clear_flags  (clear_flags),
    .sticky_ovf   (sticky_ovf),
    .sticky_err   (sticky_err)
`ifdef FP_FLAG_COUNT_EN
    ,
    .ovf_cnt      (ovf_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [33:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: a pop happens at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {30'd0, out_result, out_overflow, out_error}, 64'hdead);
      end else begin
        check("pop_data", {30'd0, out_result, out_overflow, out_error}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive a word for one cycle; queue it when the bench expects acceptance.
  task automatic push_word(input logic [31:0] d, input logic ovf, input logic err,
                           input logic accept);
    in_valid    = 1'b1;
    in_result   = d;
    in_overflow = ovf;
    in_error    = err;
    if (accept) exp_q.push_back({d, ovf, err});
    cyc();
    in_valid    = 1'b0;
    in_overflow = 1'b0;
    in_error    = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
    in_error = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_sticky", {62'd0, sticky_ovf, sticky_err}, 64'd0);

    // In-order delivery after stalling the consumer.
    push_word(32'h3F800000, 1'b0, 1'b0, 1'b1);
    push_word(32'h40000000, 1'b0, 1'b0, 1'b1);
    push_word(32'h40400000, 1'b0, 1'b0, 1'b1);
    check("level_three", 64'(level), 64'd3);
    check("head_first", 64'(out_result), 64'h3F800000);
    drain(3);
    check("level_drained", 64'(level), 64'd0);

    // Full: fifth word refused, even in the cycle a pop frees a slot.
    for (int i = 0; i < 4; i++) push_word(32'h41000000 + 32'(i), 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; in_result = 32'hBAD0BAD0;
    cyc();
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_level", 64'(level), 64'd4);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    check("after_pop_in_ready", 64'(in_ready), 64'd1);
    check("after_pop_level", 64'(level), 64'd3);
    drain(3);
    check("level_empty2", 64'(level), 64'd0);

    // Streaming at level 1 with pointer wrap.
    push_word(32'hC0000000, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(32'h42000000 + 32'(i * 3), i[0], i[1], 1'b1);
      check("stream_level", 64'(level), 64'd1);
    end
    cyc();
    out_ready = 1'b0;
    check("stream_end_level", 64'(level), 64'd0);

    // Sticky flags: set wins over a simultaneous clear.
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b1;
    push_word(32'h7F800000, 1'b1, 1'b0, 1'b1);
    clear_flags = 1'b0;
    check("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    check("sticky_err_clear", 64'(sticky_err), 64'd0);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    check("sticky_cleared", 64'(sticky_ovf), 64'd0);
    drain(1);
    check("sticky_pop_indep", 64'(sticky_ovf), 64'd0);
    push_word(32'hFFC00000, 1'b0, 1'b1, 1'b1);
    check("sticky_err_set", {62'd0, sticky_ovf, sticky_err}, 64'd1);
    drain(1);
    check("sticky_err_held", 64'(sticky_err), 64'd1);

`ifdef FP_FLAG_COUNT_EN
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(32'h43000000 + 32'(i), 1'b0, 1'b1, 1'b1);
    cyc();
    out_ready = 1'b0;
    check("err_cnt_sat", 64'(err_cnt), 64'd15);
    check("ovf_cnt_zero", 64'(ovf_cnt), 64'd0);
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
    check("err_cnt_clear", 64'(err_cnt), 64'd0);
    clear_flags = 1'b1;
    push_word(32'h7F800000, 1'b1, 1'b0, 1'b1);
    clear_flags = 1'b0;
    check("ovf_cnt_clr_push", 64'(ovf_cnt), 64'd1);
    drain(1);
`endif

    // Reset mid-operation discards stored entries.
    push_word(32'h3F800000, 1'b1, 1'b0, 1'b0);
    push_word(32'h40000000, 1'b0, 1'b0, 1'b0);
    push_word(32'h40400000, 1'b0, 1'b1, 1'b0);
    check("pre_reset_level", 64'(level), 64'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_out_result", 64'(out_result), 64'd0);
    check("mid_rst_sticky", {62'd0, sticky_ovf, sticky_err}, 64'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
